uart_rx: RTL and testbench

Serial receiver for the UART path: the receive-side counterpart of the UART transmitter. It recovers 8N1 frames (1 start, 8 data LSB first, 1 stop, no parity) from an asynchronous serial input using a clock-cycle baud counter, and presents each byte on a valid/ready parallel interface. Framing and overrun errors are flagged as single-cycle pulses.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 serial receiver with valid/ready byte output and error pulses
// Revision: 1.0
// ============================================================================
module uart_rx #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int          CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] C_LAST   = 16'(CYCLE - 1);
    localparam logic [15:0] C_SAMPLE = 16'(CYCLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_REC_BYTE = 3'd2,
        S_STOP     = 3'd3,
        S_DATA     = 3'd4
    } state_t;

    logic        s1;
    logic        s2;
    logic        s3;
    logic        fall;
    state_t      state;
    logic [15:0] cycle_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        stop_bit;
    logic        at_sample;
    logic        at_last;

    // Sync chain resets low so a line held low out of reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= rx_pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall      = s3 & ~s2;
    assign at_sample = (cycle_cnt == C_SAMPLE);
    assign at_last   = (cycle_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cycle_cnt     <= 16'd0;
            bit_cnt       <= 3'd0;
            shift_reg     <= 8'h00;
            stop_bit      <= 1'b0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
            cycle_cnt <= at_last ? 16'd0 : cycle_cnt + 16'd1;

            case (state)
                S_IDLE: begin
                    cycle_cnt <= 16'd0;
                    if (fall) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (at_sample && s2) begin
                        state     <= S_IDLE;
                        cycle_cnt <= 16'd0;
                    end else if (at_last) begin
                        state     <= S_REC_BYTE;
                        bit_cnt   <= 3'd0;
                        cycle_cnt <= 16'd0;
                    end
                end
                S_REC_BYTE: begin
                    if (at_sample) begin
                        shift_reg[bit_cnt] <= s2;
                    end
                    if (at_last) begin
                        if (bit_cnt == 3'd7) begin
                            state     <= S_STOP;
                            cycle_cnt <= 16'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                // Leaving at mid-stop-bit keeps a zero-idle next start edge visible.
                S_STOP: begin
                    if (at_sample) begin
                        stop_bit  <= s2;
                        state     <= S_DATA;
                        cycle_cnt <= 16'd0;
                    end
                end
                S_DATA: begin
                    state     <= S_IDLE;
                    cycle_cnt <= 16'd0;
                    if (!stop_bit) begin
                        rx_frame_err <= 1'b1;
                    end else if (rx_data_valid && !rx_data_ready) begin
                        rx_overrun <= 1'b1;
                    end else begin
                        rx_data       <= shift_reg;
                        rx_data_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cycle_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : self-checking bench for uart_rx (event scoreboard, timing model)
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

    localparam int CLK_FRE   = 50;
    localparam int BAUD_RATE = 115200;
    localparam int C         = CLK_FRE * 1000000 / BAUD_RATE;
    // Cycles from the driver's falling start edge to the negedge where results are visible.
    localparam int DONE      = 9 * C + C / 2 + 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_pin;
    logic       rx_data_ready;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_overrun;

    uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = byte accepted, 1 = frame error, 2 = overrun
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_hold;
        int         idle;
        int         exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  valid_hi  = 0;
    int  last_fall = 0;

    function automatic ev_t mk_ev(input int kind, input logic [7:0] data, input int at);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.at   = at;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_data_valid) valid_hi <= valid_hi + 1;
            if (rx_data_valid && rx_data_ready) obs_q.push_back(mk_ev(0, rx_data, cyc));
            if (rx_frame_err) obs_q.push_back(mk_ev(1, 8'h00, cyc));
            if (rx_overrun) obs_q.push_back(mk_ev(2, 8'h00, cyc));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits      = {stop, d, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_pin = bits[i];
            tick(C);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data, input int at);
        exp_q.push_back(mk_ev(kind, data, at));
    endtask

    task automatic compare_events(input string tag);
        check($sformatf("%s event count", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
            check($sformatf("%s ev%0d data", tag, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s ev%0d cycle", tag, i), obs_q[i].at, exp_q[i].at);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] d, input logic v,
                                 input logic fe, input logic ov);
        check($sformatf("%s rx_data", tag), rx_data, d);
        check($sformatf("%s rx_data_valid", tag), rx_data_valid, v);
        check($sformatf("%s rx_frame_err", tag), rx_frame_err, fe);
        check($sformatf("%s rx_overrun", tag), rx_overrun, ov);
    endtask

    vec_t vecs[5];

    initial begin
        int n_bytes;
        int f;
        logic [7:0] rd;
        logic       rs;
        int         ri;

        vecs[0] = '{8'hA5, 1'b1, 0,     40, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0,     0,  0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0,     0,  0, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, 0,     40, 0, 8'h55};
        vecs[4] = '{8'h3C, 1'b0, 20*C,  40, 1, 8'h00};

        rst_n         = 1'b0;
        rx_pin        = 1'b1;
        rx_data_ready = 1'b0;
        tick(5);
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(10);
        rx_data_ready = 1'b1;

        // Glitch shorter than half a bit must be rejected at the start sample point.
        rx_pin = 1'b0;
        tick(C / 4);
        rx_pin = 1'b1;
        tick(2 * C);
        compare_events("glitch");

        valid_hi = 0;
        n_bytes  = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            expect_ev(vecs[i].exp_kind, vecs[i].exp_data, last_fall + DONE);
            if (vecs[i].exp_kind == 0) n_bytes++;
            tick(vecs[i].low_hold);
            rx_pin = 1'b1;
            tick(vecs[i].idle);
        end
        check("valid high cycles with ready", valid_hi, n_bytes);
        if (obs_q.size() >= 4) begin
            check("back-to-back spacing 1", obs_q[2].at - obs_q[1].at, 10 * C);
            check("back-to-back spacing 2", obs_q[3].at - obs_q[2].at, 10 * C);
        end
        compare_events("table");

        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            ri = rs ? int'($urandom_range(0, 30)) : int'($urandom_range(10, 30));
            send_frame(rd, rs);
            if (rs) expect_ev(0, rd, last_fall + DONE);
            else    expect_ev(1, 8'h00, last_fall + DONE);
            rx_pin = 1'b1;
            tick(ri);
        end
        compare_events("random");

        rx_data_ready = 1'b0;
        tick(5);
        send_frame(8'h11, 1'b1);
        tick(20);
        check_outputs("hold 0x11", 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1);
        expect_ev(2, 8'h00, last_fall + DONE);
        tick(20);
        check_outputs("after overrun", 8'h11, 1'b1, 1'b0, 1'b0);
        f = cyc;
        rx_data_ready = 1'b1;
        tick(1);
        rx_data_ready = 1'b0;
        expect_ev(0, 8'h11, f);
        check("valid cleared by ready", rx_data_valid, 1'b0);
        compare_events("overrun");

        send_frame(8'h11, 1'b1);
        tick(20);
        check("reload 0x11 valid", rx_data_valid, 1'b1);
        obs_q.delete();
        f = cyc;
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(DONE - 1);
                rx_data_ready = 1'b1;
                tick(1);
                rx_data_ready = 1'b0;
            end
        join
        expect_ev(0, 8'h11, f + DONE - 1);
        tick(20);
        check_outputs("accept on completion", 8'h22, 1'b1, 1'b0, 1'b0);
        compare_events("same-cycle accept");

        // 0xE5: bit 4 low, bits 5..7 and stop high, so the tail has no falling edge.
        fork
            send_frame(8'hE5, 1'b1);
            begin
                tick(5 * C + C / 2);
                rst_n = 1'b0;
                #2;
                check_outputs("mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0);
                tick(2);
                rst_n = 1'b1;
            end
        join
        tick(20);
        check("no valid after reset tail", rx_data_valid, 1'b0);
        compare_events("reset tail");

        rx_data_ready = 1'b1;
        send_frame(8'hC3, 1'b1);
        expect_ev(0, 8'hC3, last_fall + DONE);
        tick(20);
        compare_events("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
